// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing types, the default 640x480@60 mode and alternate mode sets.
package vga_pkg;
    localparam int VGA_CW = 11;
    typedef logic [VGA_CW-1:0] vga_coord_t;
    typedef struct packed {
        vga_coord_t vis;
        vga_coord_t front;
        vga_coord_t sync;
        vga_coord_t back;
    } vga_timing_t;
    localparam vga_timing_t VGA_640_H = '{vis: 11'd640, front: 11'd16, sync: 11'd96, back: 11'd48};
    localparam vga_timing_t VGA_640_V = '{vis: 11'd480, front: 11'd10, sync: 11'd2, back: 11'd33};
    localparam bit VGA_640_HPOL = 1'b0;
    localparam bit VGA_640_VPOL = 1'b0;
    // 800x600@72 from a 50 MHz pixel rate, positive syncs
    localparam vga_timing_t VGA_800_H = '{vis: 11'd800, front: 11'd56, sync: 11'd120, back: 11'd64};
    localparam vga_timing_t VGA_800_V = '{vis: 11'd600, front: 11'd37, sync: 11'd6, back: 11'd23};
    localparam bit VGA_800_HPOL = 1'b1;
    localparam bit VGA_800_VPOL = 1'b1;
    // 320x240 pixel-doubled: half-rate pixels on the 640x480 raster
    localparam vga_timing_t VGA_320_H = '{vis: 11'd320, front: 11'd8, sync: 11'd48, back: 11'd24};
    localparam vga_timing_t VGA_320_V = '{vis: 11'd240, front: 11'd5, sync: 11'd1, back: 11'd16};
    function automatic int vga_total(vga_timing_t t);
        return int'(t.vis) + int'(t.front) + int'(t.sync) + int'(t.back);
    endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: enable/pixel-strobe inputs and registered timing outputs of the generator.
interface vga_timing_gen_if #(
    parameter int CW = 11,
    parameter int FRAME_W = 16
);
    logic en;
    logic pix_en;
    logic hsync;
    logic vsync;
    logic active;
    logic [CW-1:0] x_pos;
    logic [CW-1:0] y_pos;
    logic line_start;
    logic frame_start;
    logic vblank_start;
    logic [FRAME_W-1:0] frame_cnt;
    modport master (
        input  en, pix_en,
        output hsync, vsync, active, x_pos, y_pos, line_start, frame_start, vblank_start, frame_cnt
    );
    modport slave (
        output en, pix_en,
        input  hsync, vsync, active, x_pos, y_pos, line_start, frame_start, vblank_start, frame_cnt
    );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one timing axis (visible, front porch, sync, back porch) with wrap
// detection and segment decode; used once per line and once per frame.
module vga_axis_counter #(
    parameter int VIS = 640,
    parameter int FRONT = 16,
    parameter int SYNC = 96,
    parameter int BACK = 48,
    parameter int CW = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic adv,
    output logic [CW-1:0] cnt,
    output logic wrap,
    output logic in_vis,
    output logic in_sync
);
    localparam logic [CW-1:0] LAST = CW'(VIS + FRONT + SYNC + BACK - 1);
    localparam logic [CW-1:0] VIS_END = CW'(VIS);
    localparam logic [CW-1:0] SYNC_FIRST = CW'(VIS + FRONT);
    localparam logic [CW-1:0] SYNC_LAST = CW'(VIS + FRONT + SYNC - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (adv) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    always_comb begin
        wrap = adv && cnt == LAST;
        in_vis = cnt < VIS_END;
        in_sync = cnt >= SYNC_FIRST && cnt <= SYNC_LAST;
    end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync/coordinate generator stepped by a pixel strobe.
// Outputs are registered and reflect the (h, v) held on the last advancing cycle.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_VIS = int'(VGA_640_H.vis),
    parameter int H_FRONT = int'(VGA_640_H.front),
    parameter int H_SYNC = int'(VGA_640_H.sync),
    parameter int H_BACK = int'(VGA_640_H.back),
    parameter int V_VIS = int'(VGA_640_V.vis),
    parameter int V_FRONT = int'(VGA_640_V.front),
    parameter int V_SYNC = int'(VGA_640_V.sync),
    parameter int V_BACK = int'(VGA_640_V.back),
    parameter bit H_SYNC_POL = VGA_640_HPOL,
    parameter bit V_SYNC_POL = VGA_640_VPOL,
    parameter int CW = VGA_CW,
    parameter int FRAME_W = 16
) (
    input logic clk,
    input logic rst_n,
    vga_timing_gen_if.master bus
);
    localparam logic [CW-1:0] V_BLANK = CW'(V_VIS);
    logic adv, started, h_wrap, unused_v_wrap, h_vis, v_vis, h_sync, v_sync;
    logic d_hs, d_vs, d_act, d_ls, d_fs, d_vb;
    logic [CW-1:0] h, v, d_x, d_y;
    assign adv = bus.en && bus.pix_en;
    vga_axis_counter #(.VIS(H_VIS), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .CW(CW)) u_h (
        .clk(clk), .rst_n(rst_n), .clr(!bus.en), .adv(adv),
        .cnt(h), .wrap(h_wrap), .in_vis(h_vis), .in_sync(h_sync)
    );
    vga_axis_counter #(.VIS(V_VIS), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .CW(CW)) u_v (
        .clk(clk), .rst_n(rst_n), .clr(!bus.en), .adv(h_wrap),
        .cnt(v), .wrap(unused_v_wrap), .in_vis(v_vis), .in_sync(v_sync)
    );
    // Decode collapses to idle values while disabled, so one load path serves both cases.
    always_comb begin
        d_act = bus.en && h_vis && v_vis;
        d_hs = (bus.en && h_sync) ? H_SYNC_POL : !H_SYNC_POL;
        d_vs = (bus.en && v_sync) ? V_SYNC_POL : !V_SYNC_POL;
        d_x = d_act ? h : '0;
        d_y = d_act ? v : '0;
        d_ls = bus.en && h == '0;
        d_fs = d_ls && v == '0;
        d_vb = d_ls && v == V_BLANK;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            bus.hsync <= !H_SYNC_POL;
            bus.vsync <= !V_SYNC_POL;
            bus.active <= 1'b0;
            bus.x_pos <= '0;
            bus.y_pos <= '0;
            bus.line_start <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.vblank_start <= 1'b0;
        end else if (adv || !bus.en) begin
            bus.hsync <= d_hs;
            bus.vsync <= d_vs;
            bus.active <= d_act;
            bus.x_pos <= d_x;
            bus.y_pos <= d_y;
            bus.line_start <= d_ls;
            bus.frame_start <= d_fs;
            bus.vblank_start <= d_vb;
        end else begin
            bus.line_start <= 1'b0;
            bus.frame_start <= 1'b0;
            bus.vblank_start <= 1'b0;
        end
    // The frame that opens after reset or enable is not yet a completed frame.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            started <= 1'b0;
            bus.frame_cnt <= '0;
        end else if (!bus.en) begin
            started <= 1'b0;
        end else if (adv && d_fs) begin
            started <= 1'b1;
            if (started) bus.frame_cnt <= bus.frame_cnt + 1'b1;
        end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: default 640x480 instance plus a tiny 8x4 positive-sync instance,
// both compared every cycle against a linear-pixel-index model, plus directed checks.
module tb_vga_timing_gen;
    typedef struct packed {
        logic hs, vs, act;
        logic [10:0] x, y;
        logic ls, fs, vb;
        logic [15:0] fc;
    } exp_t;
    typedef struct {
        int hv, hf, hs, hb, vv, vf, vs, vb;
        bit hp, vp;
        int fmod;
    } cfg_t;
    typedef struct {
        bit pe;
        bit hs, act;
        int x, y;
        bit ls, fs;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vga_timing_gen_if ifa ();
    vga_timing_gen_if #(.CW(4), .FRAME_W(2)) ifb ();
    vga_timing_gen u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    vga_timing_gen #(
        .H_VIS(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VIS(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CW(4), .FRAME_W(2)
    ) u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    cfg_t cfg[2] = '{'{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 65536},
                     '{8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1, 4}};
    int mp[2];
    bit mfirst[2];
    exp_t me[2];

    function automatic void chk(string name, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic exp_t idle(int i, logic [15:0] fc);
        exp_t e = '0;
        e.hs = !cfg[i].hp;
        e.vs = !cfg[i].vp;
        e.fc = fc;
        return e;
    endfunction

    // Position is a linear pixel index since restart; h and v fall out by div/mod.
    task automatic mstep(int i, bit en, bit pe);
        int ht, vt, h, v;
        ht = cfg[i].hv + cfg[i].hf + cfg[i].hs + cfg[i].hb;
        vt = cfg[i].vv + cfg[i].vf + cfg[i].vs + cfg[i].vb;
        if (!en) begin
            mp[i] = 0;
            mfirst[i] = 1;
            me[i] = idle(i, me[i].fc);
        end else if (pe) begin
            h = mp[i] % ht;
            v = mp[i] / ht;
            me[i].hs = (h >= cfg[i].hv + cfg[i].hf && h < cfg[i].hv + cfg[i].hf + cfg[i].hs) ? cfg[i].hp : !cfg[i].hp;
            me[i].vs = (v >= cfg[i].vv + cfg[i].vf && v < cfg[i].vv + cfg[i].vf + cfg[i].vs) ? cfg[i].vp : !cfg[i].vp;
            me[i].act = h < cfg[i].hv && v < cfg[i].vv;
            me[i].x = me[i].act ? 11'(h) : 11'd0;
            me[i].y = me[i].act ? 11'(v) : 11'd0;
            me[i].ls = h == 0;
            me[i].fs = h == 0 && v == 0;
            me[i].vb = h == 0 && v == cfg[i].vv;
            if (me[i].fs) begin
                if (!mfirst[i]) me[i].fc = 16'((int'(me[i].fc) + 1) % cfg[i].fmod);
                mfirst[i] = 0;
            end
            mp[i] = (mp[i] + 1) % (ht * vt);
        end else begin
            me[i].ls = 0;
            me[i].fs = 0;
            me[i].vb = 0;
        end
    endtask

    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mp[i] = 0;
                mfirst[i] = 1;
                me[i] = idle(i, 16'd0);
            end
        end else begin
            mstep(0, ifa.en, ifa.pix_en);
            mstep(1, ifb.en, ifb.pix_en);
        end

    int ls_prev_a = 0, ls_gap_a = 0, hs_on_a = 0, hs_off_a = 0, hs_len_a = 0;
    int act_on_a = 0, act_len_a = 0, last_x_a = 0;
    bit hs_q_a = 1, act_q_a = 0, zero_a = 0, idle_bad_a = 0, idle_bad_b = 0;
    logic [10:0] x_q_a = '0;
    int fs_prev_b = 0, fs_gap_b = 0, vb_cnt_b = 0, vb_last_b = 0;
    int fcq[$];

    always @(negedge clk) begin
        exp_t ea, eb;
        cyc++;
        ea = '{hs: ifa.hsync, vs: ifa.vsync, act: ifa.active, x: ifa.x_pos, y: ifa.y_pos,
               ls: ifa.line_start, fs: ifa.frame_start, vb: ifa.vblank_start, fc: ifa.frame_cnt};
        eb = '{hs: ifb.hsync, vs: ifb.vsync, act: ifb.active, x: 11'(ifb.x_pos), y: 11'(ifb.y_pos),
               ls: ifb.line_start, fs: ifb.frame_start, vb: ifb.vblank_start, fc: 16'(ifb.frame_cnt)};
        chk("model_a", ea, me[0]);
        chk("model_b", eb, me[1]);
        if (ifa.line_start) begin
            ls_gap_a = cyc - ls_prev_a;
            ls_prev_a = cyc;
        end
        if (!ifa.hsync && hs_q_a) begin
            hs_off_a = cyc - ls_prev_a;
            hs_on_a = cyc;
        end
        if (ifa.hsync && !hs_q_a) hs_len_a = cyc - hs_on_a;
        if (ifa.active && !act_q_a) act_on_a = cyc;
        if (!ifa.active && act_q_a) begin
            act_len_a = cyc - act_on_a;
            last_x_a = int'(x_q_a);
            zero_a = ifa.x_pos == 0 && ifa.y_pos == 0;
        end
        hs_q_a = ifa.hsync;
        act_q_a = ifa.active;
        x_q_a = ifa.x_pos;
        if (!ifa.en && (ifa.hsync !== 1'b1 || ifa.vsync !== 1'b1 || ifa.active !== 1'b0)) idle_bad_a = 1;
        if (!ifb.en && (ifb.hsync !== 1'b0 || ifb.vsync !== 1'b0 || ifb.active !== 1'b0)) idle_bad_b = 1;
        if (ifb.frame_start) begin
            fs_gap_b = cyc - fs_prev_b;
            fs_prev_b = cyc;
            fcq.push_back(int'(ifb.frame_cnt));
            vb_last_b = vb_cnt_b;
            vb_cnt_b = 0;
        end
        if (ifb.vblank_start) vb_cnt_b++;
    end

    task automatic cyc_n(int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    vec_t tab[18];
    int fexp[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        tab = '{'{1, 0, 1, 0, 0, 1, 1}, '{0, 0, 1, 0, 0, 0, 0}, '{1, 0, 1, 1, 0, 0, 0},
                '{1, 0, 1, 2, 0, 0, 0}, '{1, 0, 1, 3, 0, 0, 0}, '{1, 0, 1, 4, 0, 0, 0},
                '{1, 0, 1, 5, 0, 0, 0}, '{1, 0, 1, 6, 0, 0, 0}, '{1, 0, 1, 7, 0, 0, 0},
                '{1, 0, 0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0},
                '{1, 1, 0, 0, 0, 0, 0}, '{1, 1, 0, 0, 0, 0, 0}, '{0, 1, 0, 0, 0, 0, 0},
                '{1, 0, 0, 0, 0, 0, 0}, '{1, 0, 0, 0, 0, 0, 0}, '{1, 0, 1, 0, 1, 1, 0}};
        rst_n = 1'b0;
        ifa.en = 1'b0;
        ifa.pix_en = 1'b0;
        ifb.en = 1'b0;
        ifb.pix_en = 1'b0;
        cyc_n(3);
        chk("rst_a_hsync", ifa.hsync, 1);
        chk("rst_a_vsync", ifa.vsync, 1);
        chk("rst_a_active", ifa.active, 0);
        chk("rst_a_fc", ifa.frame_cnt, 0);
        chk("rst_b_syncs", {ifb.hsync, ifb.vsync}, 0);
        rst_n = 1'b1;
        ifb.en = 1'b1;
        // Small mode, first line with occasional pix_en gaps.
        for (int i = 0; i < 18; i++) begin
            ifb.pix_en = tab[i].pe;
            @(negedge clk);
            chk($sformatf("tab%0d", i),
                {ifb.hsync, ifb.active, ifb.x_pos, ifb.y_pos, ifb.line_start, ifb.frame_start},
                {tab[i].hs, tab[i].act, 4'(tab[i].x), 4'(tab[i].y), tab[i].ls, tab[i].fs});
            #1;
        end
        ifb.pix_en = 1'b1;
        cyc_n(500);
        chk("b_frame_clks", fs_gap_b, 98);
        chk("b_vblank_per_frame", vb_last_b, 1);
        ifb.en = 1'b0;
        idle_bad_b = 0;
        cyc_n(1000);
        chk("b_idle_outputs", idle_bad_b, 0);
        chk("b_fc_held", ifb.frame_cnt, 1);
        chk("b_fcq_len", fcq.size(), 6);
        for (int k = 0; k < 6 && k < fcq.size(); k++) chk($sformatf("b_fc_seq%0d", k), fcq[k], fexp[k]);
        ifb.en = 1'b1;
        @(negedge clk);
        chk("b_en_rise_fs", {ifb.frame_start, ifb.line_start, ifb.frame_cnt}, {2'b11, 2'd1});
        #1;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(49) == 0) ifb.en = !ifb.en;
            ifb.pix_en = $urandom_range(2) != 0;
            cyc_n(1);
        end
        ifb.en = 1'b0;
        // Default mode at one pixel per clk.
        ifa.en = 1'b1;
        ifa.pix_en = 1'b1;
        cyc_n(1700);
        chk("a_line_clks", ls_gap_a, 800);
        chk("a_hsync_start", hs_off_a, 656);
        chk("a_hsync_len", hs_len_a, 96);
        chk("a_active_len", act_len_a, 640);
        chk("a_last_x", last_x_a, 639);
        chk("a_blank_zero", zero_a, 1);
        for (int k = 0; k < 7200; k++) begin
            ifa.pix_en = k % 4 == 0;
            cyc_n(1);
        end
        chk("a_line_clks_div4", ls_gap_a, 3200);
        ifa.pix_en = 1'b1;
        begin
            bit found = 0;
            for (int k = 0; k < 1000 && !found; k++) begin
                @(negedge clk);
                found = ifa.x_pos == 11'd300;
            end
            chk("a_reach_x300", found, 1);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("a_async_rst", {ifa.hsync, ifa.vsync, ifa.active, ifa.x_pos, ifa.line_start}, {3'b110, 11'd0, 1'b0});
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("a_post_rst_fs", {ifa.frame_start, ifa.active, ifa.frame_cnt}, {2'b11, 16'd0});
        #1;
        cyc_n(500);
        ifa.en = 1'b0;
        idle_bad_a = 0;
        cyc_n(1000);
        chk("a_idle_outputs", idle_bad_a, 0);
        chk("a_fc_held", ifa.frame_cnt, 0);
        ifa.en = 1'b1;
        @(negedge clk);
        chk("a_en_rise_fs", {ifa.frame_start, ifa.x_pos, ifa.y_pos}, {1'b1, 22'd0});
        #1;
        for (int k = 0; k < 20000; k++) begin
            if ($urandom_range(199) == 0) ifa.en = !ifa.en;
            ifa.pix_en = $urandom_range(3) != 0;
            cyc_n(1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA sync generator.
- Produces hsync/vsync, the active-video flag, pixel coordinates, and line/frame strobes for any CVT/DMT-style mode.
- Runs from the system clock, gated by a pixel-enable input, so no derived clock is needed (e.g. 100 MHz system clock with pix_en every 4th cycle gives 25 MHz pixels).
- All outputs are registered; the block feeds the tetris renderer and the frame-synchronous game tick.

Parameters:
- H_VIS, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch, in pixels
- H_SYNC, 96, horizontal sync width, in pixels
- H_BACK, 48, horizontal back porch, in pixels
- V_VIS, 480, visible lines per frame
- V_FRONT, 10, vertical front porch, in lines
- V_SYNC, 2, vertical sync width, in lines
- V_BACK, 33, vertical back porch, in lines
- H_SYNC_POL, 0, asserted level of hsync (0 = active-low)
- V_SYNC_POL, 0, asserted level of vsync
- CW, 11, coordinate/counter width; must satisfy 2^CW >= max(H_TOTAL, V_TOTAL)
- FRAME_W, 16, frame counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active-low
- en  in  1  timing enable; low = idle/blank
- pix_en  in  1  pixel strobe, one clk cycle wide
- hsync  out  1  horizontal sync, level per H_SYNC_POL
- vsync  out  1  vertical sync, level per V_SYNC_POL
- active  out  1  pixel is inside the visible area
- x_pos  out  CW  visible column; 0 when not active
- y_pos  out  CW  visible row; 0 when not active
- line_start  out  1  one-clk pulse at h=0 of every line
- frame_start  out  1  one-clk pulse at h=0, v=0
- vblank_start  out  1  one-clk pulse at h=0, v=V_VIS (game-tick point)
- frame_cnt  out  FRAME_W  completed frames; wraps

Behaviour:
- Derived totals: H_TOTAL = H_VIS + H_FRONT + H_SYNC + H_BACK (800); V_TOTAL = V_VIS + V_FRONT + V_SYNC + V_BACK (525).
- Segment order within a line and within a frame: visible, front porch, sync, back porch.
- Internal counters h, v are CW bits wide. They reset to 0 and advance only on cycles where en=1 and pix_en=1.
- h wraps from H_TOTAL-1 to 0. On that wrap, v increments; v wraps from V_TOTAL-1 to 0.
- Output latency: outputs are registered and update only on advancing cycles. Each update is a pure function of the (h, v) held during that cycle, so outputs show pixel N for the interval after pix_en N, until the next pix_en.
- Signal decode on (h, v):
  - hsync asserted iff H_VIS+H_FRONT <= h < H_VIS+H_FRONT+H_SYNC
  - vsync asserted iff V_VIS+V_FRONT <= v < V_VIS+V_FRONT+V_SYNC
  - active = (h < H_VIS) and (v < V_VIS)
  - x_pos = h and y_pos = v while active; otherwise both 0
- Strobes: line_start, frame_start and vblank_start are each high for exactly one clk, on the update cycle whose decoded (h, v) matches their condition. They are low on all other cycles, including non-pix_en cycles.
- frame_cnt increments together with the frame_start pulse, except for the first frame_start after reset or after en rises. It wraps modulo 2^FRAME_W.
- Reset: h = v = 0, frame_cnt = 0, active = 0, x_pos = y_pos = 0, all strobes = 0; hsync = !H_SYNC_POL and vsync = !V_SYNC_POL (deasserted). A reset asserted mid-line takes effect immediately. After release, timing restarts from h = v = 0.
- en low: counters clear to 0 on the next clk. Outputs go to their reset values and frame_cnt holds. When en rises, the first pix_en produces frame_start.
- pix_en tied high: the block runs at one pixel per clk, with no other behavioural change.
- Simultaneous events at h = H_TOTAL-1, v = V_TOTAL-1: both counters wrap in the same cycle, and the next update emits line_start and frame_start together.

Decomposition:
- vga_pkg holds:
  - default 640x480@60 timing localparams
  - alternate mode constant sets (800x600@72 at 50 MHz; 320x240 pixel-doubled)
  - typedef vga_coord_t (logic [CW-1:0] with CW = 11)
  - struct vga_timing_t {vis, front, sync, back} used to pass a mode as one value
- Sub-module vga_axis_counter: one generic counter with a wrap output and segment decode (in_vis, in_sync). It is instantiated once for h and once for v; the v instance is advanced by the h wrap.

Test Plan:
- Defaults, pix_en = 1, run 2 frames -> hsync low for exactly 96 pixels starting at h=656; vsync low on lines 490-491; 800x525 = 420000 clk per frame; frame_cnt = 1 after the second frame_start.
- pix_en every 4th clk -> x_pos steps 0,1,2… once per 4 clk, outputs stable between strobes, each line_start 3200 clk apart.
- Check each pulse -> active drops after x_pos = 639 (h=640) and x_pos/y_pos read 0; vblank_start is one 1-clk pulse per frame, at v=480.
- rst_n low at h=300, v=200 for 3 clk -> outputs at reset values immediately; after release frame_start appears with the first update and frame_cnt = 0.
- en low for 1000 clk mid-frame, then high -> syncs deasserted and active = 0 throughout; frame_start on the first pix_en; frame_cnt unchanged.
- H_SYNC_POL = 1, V_SYNC_POL = 1, small mode (H 8/2/2/2, V 4/1/1/1) -> hsync high at h = 10-11 only, total 14 x 7 clk per frame; FRAME_W = 2 wraps 3 -> 0.
